lfsr_decrypt_ctrl: RTL and testbench
====================================

# lfsr_decrypt_ctrl

Sequencing controller for the LFSR decryption datapath: data memory plus a bank of six parallel 6-bit LFSRs, one per maximal-length tap pattern. On a start request it:
- seeds all six LFSRs from the first encrypted preamble symbol;
- trains over the remaining preamble symbols to identify the tap pattern in use;
- reloads the LFSRs and streams the whole message through memory, writing the XOR-decrypted result.

It replaces the hard-coded cycle-count case decode in the top level with a parameterized FSM and a start/done handshake.

## Interface
Parameters:
- RD_BASE, 8'd64: address of encrypted symbol 0
- WR_BASE, 8'd0: address of decrypted symbol 0
- PRE_LEN, 7: preamble length in symbols; legal range 2..MSG_LEN
- MSG_LEN, 64: total symbols processed, preamble included; legal range 1..256
- PAD, 8'h5F: plaintext preamble character

Ports:
- clk  in  1  clock; all state updates on rising edge
- init  in  1  reset, asynchronous, active-high
- start  in  1  level; begins a run when sampled high in IDLE
- done  out  1  one-cycle pulse at end of run (success or error)
- err  out  1  held high from a failed detection until the next run begins or init
- tap_sel  out  3  binary index of detected tap pattern; valid from DECRYPT onward
- raddr  out  8  memory read address
- waddr  out  8  memory write address
- wr_en  out  1  memory write enable
- data_in  out  8  memory write data
- data_out  in  8  memory read data; combinational from raddr, same cycle
- lfsr_load  out  1  load lfsr_start into all six LFSRs at the next edge
- lfsr_en  out  1  advance all six LFSRs at the next edge
- lfsr_start  out  6  LFSR seed
- lfsr_state  in  6x6  current state of LFSR k (k = 0..5, taps 21,2D,30,33,36,39 hex)

## Operation
States: IDLE, LOAD, STEP, TRAIN, DECIDE, DECRYPT, DONE, ERR. Symbol index i is an 8-bit counter.
- IDLE: raddr=RD_BASE. If start, go to LOAD.
- LOAD:
  - raddr=RD_BASE, lfsr_load=1.
  - lfsr_start = data_out[5:0] ^ PAD[5:0]; this seed is also registered.
  - mask set to 6'b111111. Next state STEP.
- STEP: lfsr_en=1, so LFSR state becomes keystream symbol 1. Set i=1. Next state TRAIN.
- TRAIN:
  - raddr=RD_BASE+i.
  - For each k: mask[k] <= mask[k] & (lfsr_state[k] == data_out[5:0]^PAD[5:0]).
  - lfsr_en=1; i++.
  - After i=PRE_LEN-1 is processed, go to DECIDE.
- DECIDE:
  - lfsr_load=1 using the registered seed.
  - If mask is one-hot: tap_sel <= encoded index, i=0, go to DECRYPT.
  - Otherwise (zero or multiple bits set): go to ERR.
- DECRYPT:
  - raddr=RD_BASE+i, waddr=WR_BASE+wcnt, wr_en=1.
  - data_in = data_out ^ {2'b00, lfsr_state[tap_sel]}.
  - lfsr_en=1; i++ and wcnt++.
  - After i=MSG_LEN-1 is processed, go to DONE.
- DONE: done=1, then IDLE.
- ERR: done=1, err=1, no writes, then IDLE.

Rules:
- Address arithmetic is mod 256; RD_BASE+i and WR_BASE+wcnt wrap silently.
- start is ignored outside IDLE. Holding start high produces back-to-back runs; a new run clears err on entering LOAD.

## Timing
- Reset values: all outputs 0 except raddr=RD_BASE, waddr=WR_BASE. State=IDLE, mask=0, i=0, wcnt=0, err=0, tap_sel=0.
- init asserted mid-run aborts immediately: no further writes, and the LFSR bank is left as is.
- Latency, counting cycle 0 as the IDLE cycle with start=1:
  - LOAD is cycle 1, STEP is cycle 2.
  - TRAIN occupies cycles 3..PRE_LEN+1, DECIDE is cycle PRE_LEN+2.
  - DECRYPT occupies PRE_LEN+3 .. PRE_LEN+MSG_LEN+2.
  - done is high in cycle PRE_LEN+MSG_LEN+3 (74 with defaults).
- On error, done is high in cycle PRE_LEN+3.
- wr_en is high for exactly MSG_LEN cycles, fewer with stripping enabled.
- All control outputs are combinational from state and counters. There are no combinational paths from start to memory outputs.

## Configuration
- STRIP_LEADING_PAD_EN:
  - Defined: during DECRYPT, while no non-PAD plaintext symbol has yet been written, a decrypted symbol equal to PAD gets wr_en=0 and wcnt does not advance. The first non-PAD symbol lands at WR_BASE, and the run length is unchanged.
  - Undefined: every symbol is written, with wcnt == i.

## Structure
- Package lfsr_pkg holds:
  - NUM_TAPS=6;
  - tap pattern constant array (21,2D,30,33,36,39);
  - ctrl_state_t enum;
  - default PAD.
- Sub-module tap_onehot_enc: 6-bit mask in; 3-bit index and onehot flag out (combinational, exactly-one-bit check).

## Test plan
- Message "_______HELLO…" (64 symbols) encrypted with taps 6'h2D, seed 6'h1F^enc[64] → tap_sel=1, mem[0..63] equals the plaintext, done at cycle 74, err=0.
- The same scenario repeated for each of the six tap patterns → tap_sel=k for k = 0..5.
- Corrupt encrypted symbol 66 so that no pattern matches → err=1, done at cycle 10, wr_en never asserted.
- init pulsed during cycle 30 of a run → outputs return to reset values asynchronously, no writes after the pulse, a new run completes normally.
- start held high for two runs → second LOAD follows the first done by one cycle (IDLE), with identical results.
- With STRIP_LEADING_PAD_EN, 9 leading '_' → first non-'_' symbol at mem[0], wr_en high for 55 cycles.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR decryption controller and its datapath.
package lfsr_pkg;

  localparam int unsigned NUM_TAPS = 6;

  // Feedback tap patterns of the six parallel LFSRs, indexed by tap_sel.
  localparam logic [5:0] TAPS [NUM_TAPS] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

  localparam logic [7:0] PAD_DEFAULT = 8'h5F;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStep,
    StTrain,
    StDecide,
    StDecrypt,
    StDone,
    StErr
  } ctrl_state_t;

endpackage

// File: rtl/lfsr_decrypt_ctrl_if.sv
// Memory and LFSR-bank bus between the decrypt controller (master) and its datapath (slave).
interface lfsr_decrypt_ctrl_if;
  import lfsr_pkg::*;

  logic [7:0]                raddr;
  logic [7:0]                waddr;
  logic                      wr_en;
  logic [7:0]                data_in;
  logic [7:0]                data_out;
  logic                      lfsr_load;
  logic                      lfsr_en;
  logic [5:0]                lfsr_start;
  logic [NUM_TAPS-1:0][5:0]  lfsr_state;

  modport master (
    output raddr, waddr, wr_en, data_in, lfsr_load, lfsr_en, lfsr_start,
    input  data_out, lfsr_state
  );

  modport slave (
    input  raddr, waddr, wr_en, data_in, lfsr_load, lfsr_en, lfsr_start,
    output data_out, lfsr_state
  );

endinterface

// File: rtl/lfsr_decrypt_ctrl_tap_onehot_enc.sv
// Encodes the surviving-tap mask to a binary index and flags whether exactly one bit is set.
module tap_onehot_enc
  import lfsr_pkg::*;
(
  input  logic [NUM_TAPS-1:0] mask,
  output logic [2:0]          idx,
  output logic                onehot
);

  always_comb begin
    idx = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (mask[k]) idx = 3'(k);
    end
    // Clearing the lowest set bit leaves zero only for a single-bit mask.
    onehot = (mask != '0) && ((mask & (mask - NUM_TAPS'(1))) == '0);
  end

endmodule

// File: rtl/lfsr_decrypt_ctrl.sv
// Sequencer for LFSR decryption: seed, train to find the tap pattern, then decrypt the message.
// Optional STRIP_LEADING_PAD_EN drops leading PAD symbols from the written plaintext.
module lfsr_decrypt_ctrl
  import lfsr_pkg::*;
#(
  parameter logic [7:0]  RD_BASE = 8'd64,
  parameter logic [7:0]  WR_BASE = 8'd0,
  parameter int unsigned PRE_LEN = 7,
  parameter int unsigned MSG_LEN = 64,
  parameter logic [7:0]  PAD     = PAD_DEFAULT
) (
  input  logic                clk,
  input  logic                init,
  input  logic                start,
  output logic                done,
  output logic                err,
  output logic [2:0]          tap_sel,
  lfsr_decrypt_ctrl_if.master bus
);

  localparam logic [7:0] PreLast = 8'(PRE_LEN - 1);
  localparam logic [7:0] MsgLast = 8'(MSG_LEN - 1);

  ctrl_state_t         state_q, state_d;
  logic [NUM_TAPS-1:0] mask_q, mask_d;
  logic [5:0]          seed_q, seed_d;
  logic [7:0]          i_q, i_d;
  logic [7:0]          wcnt_q, wcnt_d;
  logic                err_q, err_d;
  logic [2:0]          tap_sel_q, tap_sel_d;
`ifdef STRIP_LEADING_PAD_EN
  logic                seen_q, seen_d;
`endif

  logic [2:0]          enc_idx;
  logic                enc_onehot;
  logic [5:0]          plain;
  logic [5:0]          key;
  logic [7:0]          dec;

  tap_onehot_enc u_enc (
    .mask   (mask_q),
    .idx    (enc_idx),
    .onehot (enc_onehot)
  );

  assign err     = err_q;
  assign tap_sel = tap_sel_q;

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    seed_d        = seed_q;
    i_d           = i_q;
    wcnt_d        = wcnt_q;
    err_d         = err_q;
    tap_sel_d     = tap_sel_q;
`ifdef STRIP_LEADING_PAD_EN
    seen_d        = seen_q;
`endif
    done          = 1'b0;
    bus.raddr     = RD_BASE;
    bus.waddr     = WR_BASE + wcnt_q;
    bus.wr_en     = 1'b0;
    bus.data_in   = '0;
    bus.lfsr_load = 1'b0;
    bus.lfsr_en   = 1'b0;
    bus.lfsr_start = '0;

    // Preamble plaintext is PAD, so this is the keystream symbol for the current read.
    plain = bus.data_out[5:0] ^ PAD[5:0];
    key   = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (tap_sel_q == 3'(k)) key = bus.lfsr_state[k];
    end
    dec = bus.data_out ^ {2'b00, key};

    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d   = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        bus.lfsr_load  = 1'b1;
        bus.lfsr_start = plain;
        seed_d         = plain;
        mask_d         = '1;
        wcnt_d         = '0;
        state_d        = StStep;
      end
      StStep: begin
        bus.lfsr_en = 1'b1;
        i_d         = 8'd1;
        state_d     = StTrain;
      end
      StTrain: begin
        bus.raddr = RD_BASE + i_q;
        for (int k = 0; k < NUM_TAPS; k++) begin
          mask_d[k] = mask_q[k] & (bus.lfsr_state[k] == plain);
        end
        bus.lfsr_en = 1'b1;
        i_d         = i_q + 8'd1;
        if (i_q == PreLast) state_d = StDecide;
      end
      StDecide: begin
        bus.lfsr_load  = 1'b1;
        bus.lfsr_start = seed_q;
        if (enc_onehot) begin
          tap_sel_d = enc_idx;
          i_d       = '0;
          wcnt_d    = '0;
`ifdef STRIP_LEADING_PAD_EN
          seen_d    = 1'b0;
`endif
          state_d   = StDecrypt;
        end else begin
          err_d   = 1'b1;
          state_d = StErr;
        end
      end
      StDecrypt: begin
        bus.raddr   = RD_BASE + i_q;
        bus.data_in = dec;
`ifdef STRIP_LEADING_PAD_EN
        if (seen_q || (dec != PAD)) begin
          bus.wr_en = 1'b1;
          wcnt_d    = wcnt_q + 8'd1;
          seen_d    = 1'b1;
        end
`else
        bus.wr_en = 1'b1;
        wcnt_d    = wcnt_q + 8'd1;
`endif
        bus.lfsr_en = 1'b1;
        i_d         = i_q + 8'd1;
        if (i_q == MsgLast) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q   <= StIdle;
      mask_q    <= '0;
      seed_q    <= '0;
      i_q       <= '0;
      wcnt_q    <= '0;
      err_q     <= 1'b0;
      tap_sel_q <= '0;
`ifdef STRIP_LEADING_PAD_EN
      seen_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      seed_q    <= seed_d;
      i_q       <= i_d;
      wcnt_q    <= wcnt_d;
      err_q     <= err_d;
      tap_sel_q <= tap_sel_d;
`ifdef STRIP_LEADING_PAD_EN
      seen_q    <= seen_d;
`endif
    end
  end

endmodule

// File: tb/tb_lfsr_decrypt_ctrl.sv
// Directed self-checking bench for lfsr_decrypt_ctrl with a behavioural memory and LFSR bank.
module tb_lfsr_decrypt_ctrl;
  import lfsr_pkg::*;

  localparam int         PreLen = 7;
  localparam int         MsgLen = 64;
  localparam logic [7:0] RdBase = 8'd64;
`ifdef STRIP_LEADING_PAD_EN
  localparam bit         Strip  = 1'b1;
`else
  localparam bit         Strip  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       init = 1'b1;
  logic       start = 1'b0;
  logic       done;
  logic       err;
  logic [2:0] tap_sel;

  int n_checks = 0;
  int n_errors = 0;

  lfsr_decrypt_ctrl_if bus ();

  lfsr_decrypt_ctrl dut (
    .clk     (clk),
    .init    (init),
    .start   (start),
    .done    (done),
    .err     (err),
    .tap_sel (tap_sel),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [NUM_TAPS-1:0][5:0] bank;
  logic [7:0] rom [256];
  logic [7:0] ram [256];
  logic [7:0] pt  [MsgLen];
  logic       clr_ram = 1'b0;

  function automatic logic [5:0] lfsr_next(input logic [5:0] s, input logic [5:0] t);
    return {s[4:0], ^(s & t)};
  endfunction

  function automatic logic [5:0] ks_at(input int k, input logic [5:0] seed, input int n);
    logic [5:0] s = seed;
    for (int j = 0; j < n; j++) s = lfsr_next(s, TAPS[k]);
    return s;
  endfunction

  assign bus.data_out   = rom[bus.raddr];
  assign bus.lfsr_state = bank;

  always @(posedge clk) begin
    if (bus.lfsr_load) begin
      for (int k = 0; k < NUM_TAPS; k++) bank[k] <= bus.lfsr_start;
    end else if (bus.lfsr_en) begin
      for (int k = 0; k < NUM_TAPS; k++) bank[k] <= lfsr_next(bank[k], TAPS[k]);
    end
    if (clr_ram) begin
      for (int a = 0; a < 256; a++) ram[a] <= 8'hEE;
    end else if (bus.wr_en) begin
      ram[bus.waddr] <= bus.data_in;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // First seed for which tap k's preamble keystream differs from every other tap's.
  function automatic logic [5:0] pick_seed(input int k);
    bit uniq;
    bit same;
    for (int s = 1; s < 64; s++) begin
      uniq = 1'b1;
      for (int m = 0; m < NUM_TAPS; m++) begin
        if (m != k) begin
          same = 1'b1;
          for (int j = 1; j < PreLen; j++) begin
            if (ks_at(m, 6'(s), j) != ks_at(k, 6'(s), j)) same = 1'b0;
          end
          if (same) uniq = 1'b0;
        end
      end
      if (uniq) return 6'(s);
    end
    return 6'd1;
  endfunction

  // Taps that would survive training when preamble symbol 2 is corrupted by x.
  function automatic logic [NUM_TAPS-1:0] model_mask(input int k, input logic [5:0] seed,
                                                     input logic [5:0] x);
    logic [NUM_TAPS-1:0] m_out = '1;
    logic [5:0] want;
    for (int m = 0; m < NUM_TAPS; m++) begin
      for (int j = 1; j < PreLen; j++) begin
        want = ks_at(k, seed, j) ^ ((j == 2) ? x : 6'd0);
        if (ks_at(m, seed, j) != want) m_out[m] = 1'b0;
      end
    end
    return m_out;
  endfunction

  task automatic load_message(input int k, input logic [5:0] seed, input int lead,
                              input logic [5:0] x);
    for (int i = 0; i < MsgLen; i++) begin
      pt[i] = (i < lead) ? PAD_DEFAULT : 8'(8'h41 + (i - lead + 7) % 26);
      rom[RdBase + 8'(i)] = pt[i] ^ {2'b00, ks_at(k, seed, i)};
    end
    rom[RdBase + 8'd2] = rom[RdBase + 8'd2] ^ {2'b00, x};
  endtask

  task automatic clear_ram();
    @(negedge clk) clr_ram = 1'b1;
    @(negedge clk) clr_ram = 1'b0;
  endtask

  function automatic int ram_mismatches(input int lead, input bit exp_err);
    int bad = 0;
    int nw = exp_err ? 0 : (Strip ? MsgLen - lead : MsgLen);
    int off = Strip ? lead : 0;
    logic [7:0] expv;
    for (int j = 0; j < MsgLen; j++) begin
      expv = (j < nw) ? pt[j + off] : 8'hEE;
      if (ram[j] !== expv) bad++;
    end
    return bad;
  endfunction

  task automatic wait_done(input int budget, output int dcyc, output int wcnt,
                           output logic derr, output logic [2:0] dtap);
    dcyc = -1;
    wcnt = 0;
    derr = 1'b0;
    dtap = '0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start = 1'b0;
      if (bus.wr_en) wcnt++;
      if (done) begin
        dcyc = c;
        derr = err;
        dtap = tap_sel;
        break;
      end
    end
  endtask

  task automatic run_and_check(input string name, input int k, input int lead, input bit corrupt);
    logic [5:0] seed = pick_seed(k);
    logic [5:0] x = '0;
    int dcyc, wcnt;
    logic derr;
    logic [2:0] dtap;
    if (corrupt) begin
      for (int v = 1; v < 64; v++) begin
        if (model_mask(k, seed, 6'(v)) == '0) begin
          x = 6'(v);
          break;
        end
      end
    end
    load_message(k, seed, lead, x);
    clear_ram();
    @(negedge clk) start = 1'b1;
    wait_done(300, dcyc, wcnt, derr, dtap);
    check_eq({name, "_done_cycle"}, dcyc, corrupt ? PreLen + 3 : PreLen + MsgLen + 3);
    check_eq({name, "_err"}, derr, corrupt);
    if (!corrupt) check_eq({name, "_tap_sel"}, dtap, k);
    check_eq({name, "_wr_cycles"}, wcnt, corrupt ? 0 : (Strip ? MsgLen - lead : MsgLen));
    check_eq({name, "_ram_bad"}, ram_mismatches(lead, corrupt), 0);
    @(posedge clk);
    #1;
    check_eq({name, "_err_hold"}, err, corrupt);
  endtask

  task automatic check_idle_outputs(input string name);
    check_eq({name, "_raddr"}, bus.raddr, RdBase);
    check_eq({name, "_waddr"}, bus.waddr, 8'd0);
    check_eq({name, "_wr_en"}, bus.wr_en, 1'b0);
    check_eq({name, "_data_in"}, bus.data_in, 8'd0);
    check_eq({name, "_lfsr_load"}, bus.lfsr_load, 1'b0);
    check_eq({name, "_lfsr_en"}, bus.lfsr_en, 1'b0);
    check_eq({name, "_lfsr_start"}, bus.lfsr_start, 6'd0);
    check_eq({name, "_done"}, done, 1'b0);
    check_eq({name, "_err"}, err, 1'b0);
    check_eq({name, "_tap_sel"}, tap_sel, 3'd0);
  endtask

  initial begin
    int first_done, second_done, load2, wcnt, n;
    for (int a = 0; a < 256; a++) rom[a] = 8'h00;
    bank = '0;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    init = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");

    run_and_check("tap1_main", 1, PreLen, 1'b0);
    for (int k = 0; k < NUM_TAPS; k++) run_and_check($sformatf("tap%0d", k), k, PreLen, 1'b0);
    run_and_check("corrupt", 1, PreLen, 1'b1);

    // Abort a run in its 30th cycle, mid-decrypt.
    load_message(2, pick_seed(2), PreLen, 6'd0);
    clear_ram();
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start = 1'b0;
    end
    #1 init = 1'b1;
    #1;
    check_idle_outputs("abort");
    @(negedge clk);
    @(negedge clk) init = 1'b0;
    wcnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.wr_en) wcnt++;
    end
    check_eq("abort_no_writes", wcnt, 0);
    n = 20 - (Strip ? PreLen : 0);
    check_eq("abort_last_write", ram[n - 1], pt[19]);
    check_eq("abort_next_empty", ram[n], 8'hEE);
    run_and_check("after_abort", 2, PreLen, 1'b0);

    // start held high across two runs.
    load_message(3, pick_seed(3), PreLen, 6'd0);
    clear_ram();
    first_done = -1;
    second_done = -1;
    load2 = -1;
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (first_done < 0) first_done = c;
        else second_done = c;
      end
      if (first_done >= 0 && c > first_done && bus.lfsr_load && load2 < 0) load2 = c;
      if (load2 >= 0) start = 1'b0;
      if (second_done >= 0) break;
    end
    check_eq("b2b_first_done", first_done, PreLen + MsgLen + 3);
    check_eq("b2b_second_load", load2, PreLen + MsgLen + 5);
    check_eq("b2b_second_done", second_done, 2 * (PreLen + MsgLen + 3) + 1);
    check_eq("b2b_tap_sel", tap_sel, 3'd3);
    check_eq("b2b_ram_bad", ram_mismatches(PreLen, 1'b0), 0);
    @(posedge clk);

    run_and_check("lead9", 4, 9, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
